// File: rtl/vec_pkg.sv
// ============================================================================
//  Module      : vec_pkg
//  Description : Shared types and sizing constants for the vector MAC sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vec_pkg;

    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int ACCW  = 40;
    localparam int FRAC  = 15;

    localparam int c_IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        OP_VMUL = 2'b00,
        OP_VDOT = 2'b01,
        OP_VMAC = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic isValidOp(input logic [1:0] op);
        return op != OP_RSVD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vec_mac_sequencer_if.sv
// ============================================================================
//  Module      : vec_mac_sequencer_if
//  Description : Execute-stage request/response bundle for the MAC sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vec_mac_sequencer_if;
    import vec_pkg::*;

    logic                StartE;
    logic [1:0]          OpE;
    logic [LANES*DW-1:0] SrcAE;
    logic [LANES*DW-1:0] SrcBE;
    logic [ACCW-1:0]     AccInE;
    logic                FlushE;
    logic                Busy;
    logic                ResultValid;
    logic [LANES*DW-1:0] VecResult;
    logic [ACCW-1:0]     AccResult;

    modport master (
        output StartE, OpE, SrcAE, SrcBE, AccInE, FlushE,
        input  Busy, ResultValid, VecResult, AccResult
    );

    modport slave (
        input  StartE, OpE, SrcAE, SrcBE, AccInE, FlushE,
        output Busy, ResultValid, VecResult, AccResult
    );

endinterface

`default_nettype wire

// File: rtl/q15_mul_round_sat.sv
// ============================================================================
//  Module      : q15_mul_round_sat
//  Description : Shared signed multiplier with round-half-up and saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module q15_mul_round_sat #(
    parameter int DW   = 16,
    parameter int FRAC = 15
) (
    input  logic signed [DW-1:0]   i_a,
    input  logic signed [DW-1:0]   i_b,
    output logic signed [2*DW-1:0] o_prod,
    output logic [DW-1:0]          o_q15
);

    // One guard bit keeps the rounding add from overflowing at -1 * -1.
    localparam int c_PW = 2 * DW + 1;
    localparam logic signed [c_PW-1:0] c_HALF = c_PW'(2 ** (FRAC - 1));
    localparam logic signed [c_PW-1:0] c_MAX  = c_PW'((2 ** (DW - 1)) - 1);
    localparam logic signed [c_PW-1:0] c_MIN  = -(c_MAX + c_PW'(1));

    logic signed [2*DW-1:0] w_aExt;
    logic signed [2*DW-1:0] w_bExt;
    logic signed [c_PW-1:0] w_rounded;
    logic signed [c_PW-1:0] w_shifted;

    assign w_aExt    = {{DW{i_a[DW-1]}}, i_a};
    assign w_bExt    = {{DW{i_b[DW-1]}}, i_b};
    assign o_prod    = w_aExt * w_bExt;
    assign w_rounded = $signed({o_prod[2*DW-1], o_prod}) + c_HALF;
    assign w_shifted = w_rounded >>> FRAC;

    always_comb begin
        o_q15 = w_shifted[DW-1:0];
        if (w_shifted > c_MAX) begin
            o_q15 = c_MAX[DW-1:0];
        end else if (w_shifted < c_MIN) begin
            o_q15 = c_MIN[DW-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/vec_mac_sequencer.sv
// ============================================================================
//  Module      : vec_mac_sequencer
//  Description : Steps VMUL/VDOT/VMAC one lane per cycle through one multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_mac_sequencer
    import vec_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    vec_mac_sequencer_if.slave  bus
);

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(LANES - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    state_t                 r_state;
    state_t                 w_nextState;
    op_t                    r_op;
    logic [c_IDX_W-1:0]     r_laneIdx;
    logic [LANES*DW-1:0]    r_srcA;
    logic [LANES*DW-1:0]    r_srcB;
    logic [LANES*DW-1:0]    r_vecResult;
    logic [ACCW-1:0]        r_acc;
    logic [ACCW-1:0]        r_accResult;
    logic                   r_resultValid;

    logic                   w_canStart;
    logic                   w_accept;
    logic                   w_runStep;
    logic                   w_lastLane;
    int                     w_laneBase;
    logic signed [DW-1:0]   w_laneA;
    logic signed [DW-1:0]   w_laneB;
    logic signed [2*DW-1:0] w_prod;
    logic [DW-1:0]          w_laneQ15;
    logic [ACCW-1:0]        w_prodExt;
    logic [ACCW-1:0]        w_accSum;

    // Flush outranks start, so a start coinciding with a flush never launches.
    assign w_canStart = (r_state == IDLE) || (r_state == DONE);
    assign w_accept   = bus.StartE && isValidOp(bus.OpE) && w_canStart && !bus.FlushE;
    assign w_runStep  = (r_state == RUN) && !bus.FlushE;
    assign w_lastLane = (r_laneIdx == c_LAST_IDX);

    assign w_laneBase = int'(r_laneIdx) * DW;
    assign w_laneA    = r_srcA[w_laneBase +: DW];
    assign w_laneB    = r_srcB[w_laneBase +: DW];

    q15_mul_round_sat #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_mul (
        .i_a    (w_laneA),
        .i_b    (w_laneB),
        .o_prod (w_prod),
        .o_q15  (w_laneQ15)
    );

    assign w_prodExt = {{(ACCW - 2 * DW){w_prod[2*DW-1]}}, w_prod};
    assign w_accSum  = r_acc + w_prodExt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (bus.FlushE) begin
                    w_nextState = IDLE;
                end else if (w_lastLane) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = w_accept ? RUN : IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Results are committed on the last RUN edge so they are visible in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op          <= OP_VMUL;
            r_laneIdx     <= '0;
            r_srcA        <= '0;
            r_srcB        <= '0;
            r_vecResult   <= '0;
            r_acc         <= '0;
            r_accResult   <= '0;
            r_resultValid <= 1'b0;
        end else begin
            r_resultValid <= w_runStep && w_lastLane;
            if (w_accept) begin
                r_srcA    <= bus.SrcAE;
                r_srcB    <= bus.SrcBE;
                r_op      <= op_t'(bus.OpE);
                r_acc     <= (op_t'(bus.OpE) == OP_VMAC) ? bus.AccInE : '0;
                r_laneIdx <= '0;
            end else if (w_runStep) begin
                r_laneIdx <= r_laneIdx + c_IDX_ONE;
                if (r_op == OP_VMUL) begin
                    r_vecResult[w_laneBase +: DW] <= w_laneQ15;
                end else begin
                    r_acc <= w_accSum;
                    if (w_lastLane) begin
                        r_accResult <= w_accSum;
                    end
                end
            end
        end
    end

    assign bus.Busy        = (r_state == RUN) || w_accept;
    assign bus.ResultValid = r_resultValid;
    assign bus.VecResult   = r_vecResult;
    assign bus.AccResult   = r_accResult;

endmodule

`default_nettype wire

// File: tb/tb_vec_mac_sequencer.sv
// ============================================================================
//  Module      : tb_vec_mac_sequencer
//  Description : Vector table plus corner sequences for vec_mac_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vec_mac_sequencer;
    import vec_pkg::*;

    typedef struct {
        logic [1:0]          op;
        logic [LANES*DW-1:0] a;
        logic [LANES*DW-1:0] b;
        logic [ACCW-1:0]     accIn;
        logic [LANES*DW-1:0] expMain;
    } vec_t;

    typedef struct {
        logic [LANES*DW-1:0] vec;
        logic [ACCW-1:0]     acc;
    } sb_t;

    localparam int c_NVEC = 9;

    logic                clk = 1'b0;
    logic                reset;
    int                  total = 0;
    int                  bad = 0;
    sb_t                 sbQ[$];
    logic [LANES*DW-1:0] mVec;
    logic [ACCW-1:0]     mAcc;
    vec_t                tbl[c_NVEC];

    vec_mac_sequencer_if bus();

    vec_mac_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] mulQ15(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
        longint p;
        longint r;
        p = longint'(a) * longint'(b);
        r = (p + 64'sd16384) >>> 15;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return r[DW-1:0];
    endfunction

    function automatic logic [LANES*DW-1:0] vmulModel(input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] b);
        logic [LANES*DW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) r[i*DW +: DW] = mulQ15(a[i*DW +: DW], b[i*DW +: DW]);
        return r;
    endfunction

    function automatic logic [ACCW-1:0] dotModel(input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] b,
                                                 input logic [ACCW-1:0] seed);
        longint s;
        s = longint'(seed);
        for (int i = 0; i < LANES; i++)
            s += longint'($signed(a[i*DW +: DW])) * longint'($signed(b[i*DW +: DW]));
        return s[ACCW-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic void pushExp(input logic [1:0] op, input logic [63:0] res);
        sb_t e;
        if (op == 2'b00) mVec = res;
        else mAcc = res[ACCW-1:0];
        e.vec = mVec;
        e.acc = mAcc;
        sbQ.push_back(e);
    endfunction

    task automatic popCheck(input string name);
        sb_t e;
        if (sbQ.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s/unexpectedValid: got pulse want none", name);
        end else begin
            e = sbQ.pop_front();
            check({name, "/vec"}, bus.VecResult, e.vec);
            check({name, "/acc"}, 64'(bus.AccResult), 64'(e.acc));
        end
    endtask

    task automatic runOp(input vec_t v, input string name);
        int   rvCycle;
        logic busyOk;
        @(negedge clk);
        bus.StartE = 1'b1;
        bus.OpE    = v.op;
        bus.SrcAE  = v.a;
        bus.SrcBE  = v.b;
        bus.AccInE = v.accIn;
        pushExp(v.op, v.expMain);
        #1;
        busyOk  = (bus.Busy === 1'b1) && (bus.ResultValid === 1'b0);
        rvCycle = -1;
        for (int c = 1; c <= 20 && rvCycle < 0; c++) begin
            @(negedge clk);
            bus.StartE = 1'b0;
            #1;
            if (bus.ResultValid === 1'b1) begin
                rvCycle = c;
                popCheck(name);
            end
            if (bus.Busy !== ((c <= LANES) ? 1'b1 : 1'b0)) busyOk = 1'b0;
        end
        check({name, "/latency"}, 64'(rvCycle), 64'(LANES + 1));
        check({name, "/busy"}, 64'(busyOk), 64'd1);
        @(negedge clk);
        #1;
        check({name, "/pulse"}, 64'(bus.ResultValid), 64'd0);
    endtask

    initial begin
        logic [15:0]         rvMask;
        logic [15:0]         busyMask;
        logic                sawRv;
        logic [LANES*DW-1:0] fa;
        logic [LANES*DW-1:0] fb;
        logic [LANES*DW-1:0] newVec;

        bus.StartE = 1'b0;
        bus.OpE    = 2'b00;
        bus.SrcAE  = '0;
        bus.SrcBE  = '0;
        bus.AccInE = '0;
        bus.FlushE = 1'b0;
        reset      = 1'b1;

        tbl[0] = '{op: 2'b00, a: {4{16'h4000}}, b: {4{16'h4000}}, accIn: 40'h0, expMain: {4{16'h2000}}};
        tbl[1] = '{op: 2'b00, a: {16'h7FFF, 16'hFFFF, 16'h8000, 16'h8000},
                   b: {16'h7FFF, 16'hFFFF, 16'h7FFF, 16'h8000}, accIn: 40'h0,
                   expMain: {16'h7FFE, 16'h0000, 16'h8001, 16'h7FFF}};
        tbl[2] = '{op: 2'b01, a: {16'd4, 16'd3, 16'd2, 16'd1}, b: {16'd8, 16'd7, 16'd6, 16'd5},
                   accIn: 40'd999, expMain: 64'd70};
        tbl[3] = '{op: 2'b10, a: {16'd4, 16'd3, 16'd2, 16'd1}, b: {16'd8, 16'd7, 16'd6, 16'd5},
                   accIn: 40'd100, expMain: 64'd170};
        tbl[4] = '{op: 2'b01, a: {4{16'h8000}}, b: {4{16'h8000}}, accIn: 40'h0, expMain: 64'h0100000000};
        tbl[5] = '{op: 2'b10, a: {48'h0, 16'h0001}, b: {48'h0, 16'h0001}, accIn: 40'hFFFFFFFFFF, expMain: 64'h0};
        tbl[6] = '{op: 2'b10, a: {48'h0, 16'h7FFF}, b: {48'h0, 16'h7FFF}, accIn: 40'h7FFFFFFFFF,
                   expMain: 64'h803FFF0000};
        tbl[7].op      = 2'b00;
        tbl[7].a       = {$urandom, $urandom};
        tbl[7].b       = {$urandom, $urandom};
        tbl[7].accIn   = 40'h0;
        tbl[7].expMain = vmulModel(tbl[7].a, tbl[7].b);
        tbl[8].op      = 2'b10;
        tbl[8].a       = {$urandom, $urandom};
        tbl[8].b       = {$urandom, $urandom};
        tbl[8].accIn   = {8'($urandom), $urandom};
        tbl[8].expMain = {24'h0, dotModel(tbl[8].a, tbl[8].b, tbl[8].accIn)};

        repeat (2) @(negedge clk);
        #1;
        check("reset/busy", 64'(bus.Busy), 64'd0);
        check("reset/valid", 64'(bus.ResultValid), 64'd0);
        check("reset/vec", bus.VecResult, 64'd0);
        check("reset/acc", 64'(bus.AccResult), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        mVec  = '0;
        mAcc  = '0;

        for (int i = 0; i < c_NVEC; i++) runOp(tbl[i], $sformatf("vec%0d", i));

        // VMUL flushed on its third RUN cycle: lanes 0 and 1 land, lanes 2 and 3 keep old data.
        fa     = {4{16'h4000}};
        fb     = {16'h7FFF, 16'h7FFF, 16'h2000, 16'hC000};
        newVec = vmulModel(fa, fb);
        sawRv  = 1'b0;
        @(negedge clk);
        bus.StartE = 1'b1; bus.OpE = 2'b00; bus.SrcAE = fa; bus.SrcBE = fb;
        @(negedge clk); bus.StartE = 1'b0; #1; sawRv |= bus.ResultValid;
        @(negedge clk); #1; sawRv |= bus.ResultValid;
        @(negedge clk); bus.FlushE = 1'b1; #1; sawRv |= bus.ResultValid;
        @(negedge clk); bus.FlushE = 1'b0; #1;
        check("flushMul/idle", 64'(bus.Busy), 64'd0);
        repeat (6) begin @(negedge clk); #1; sawRv |= bus.ResultValid; end
        mVec = {mVec[LANES*DW-1:2*DW], newVec[2*DW-1:0]};
        check("flushMul/noValid", 64'(sawRv), 64'd0);
        check("flushMul/lanes", bus.VecResult, mVec);

        // VDOT flushed on its second RUN cycle.
        sawRv = 1'b0;
        @(negedge clk);
        bus.StartE = 1'b1; bus.OpE = 2'b01; bus.SrcAE = tbl[2].a; bus.SrcBE = tbl[2].b;
        @(negedge clk); bus.StartE = 1'b0; #1; sawRv |= bus.ResultValid;
        @(negedge clk); bus.FlushE = 1'b1; #1; sawRv |= bus.ResultValid;
        @(negedge clk); bus.FlushE = 1'b0; #1;
        check("flushDot/idle", 64'(bus.Busy), 64'd0);
        sawRv |= bus.ResultValid;
        repeat (6) begin @(negedge clk); #1; sawRv |= bus.ResultValid; end
        check("flushDot/noValid", 64'(sawRv), 64'd0);
        check("flushDot/accKept", 64'(bus.AccResult), 64'(mAcc));

        // Start with flush in IDLE is refused.
        @(negedge clk); bus.StartE = 1'b1; bus.OpE = 2'b00; bus.FlushE = 1'b1; #1;
        check("flushStart/busy", 64'(bus.Busy), 64'd0);
        @(negedge clk); bus.StartE = 1'b0; bus.FlushE = 1'b0; #1;
        check("flushStart/noRun", 64'(bus.Busy), 64'd0);

        // Flush in DONE: pulse still fires, held start is refused.
        rvMask = '0; busyMask = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) begin
                bus.StartE = 1'b1; bus.OpE = 2'b01; bus.SrcAE = tbl[4].a; bus.SrcBE = tbl[4].b;
                pushExp(2'b01, tbl[4].expMain);
            end
            if (c == 5) bus.FlushE = 1'b1;
            if (c == 6) begin bus.StartE = 1'b0; bus.FlushE = 1'b0; end
            #1;
            if (bus.ResultValid === 1'b1) begin rvMask[c] = 1'b1; popCheck("flushDone"); end
            busyMask[c] = bus.Busy;
        end
        check("flushDone/validCycles", 64'(rvMask), 64'h0020);
        check("flushDone/busyCycles", 64'(busyMask), 64'h001F);

        // Start held through DONE; operand change during RUN must not leak into the first op.
        rvMask = '0; busyMask = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 0) begin
                bus.StartE = 1'b1; bus.OpE = 2'b01; bus.SrcAE = tbl[2].a; bus.SrcBE = tbl[2].b;
                bus.AccInE = 40'd5;
                pushExp(2'b01, 64'(dotModel(tbl[2].a, tbl[2].b, 40'd0)));
            end
            if (c == 1) begin
                bus.SrcAE = tbl[8].a;
                pushExp(2'b01, 64'(dotModel(tbl[8].a, tbl[2].b, 40'd0)));
            end
            if (c == 6) bus.StartE = 1'b0;
            #1;
            if (bus.ResultValid === 1'b1) begin rvMask[c] = 1'b1; popCheck("b2b"); end
            busyMask[c] = bus.Busy;
        end
        check("b2b/validCycles", 64'(rvMask), 64'h0420);
        check("b2b/busyCycles", 64'(busyMask), 64'h03FF);

        // Reserved opcode never starts.
        rvMask = '0; busyMask = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin bus.StartE = 1'b1; bus.OpE = 2'b11; end
            if (c == 3) bus.StartE = 1'b0;
            #1;
            rvMask[c]   = bus.ResultValid;
            busyMask[c] = bus.Busy;
        end
        check("rsvd/busy", 64'(busyMask), 64'h0);
        check("rsvd/noValid", 64'(rvMask), 64'h0);

        // Reset in RUN clears everything and suppresses the pulse.
        sawRv = 1'b0;
        @(negedge clk);
        bus.StartE = 1'b1; bus.OpE = 2'b10; bus.SrcAE = tbl[8].a; bus.SrcBE = tbl[8].b;
        bus.AccInE = tbl[8].accIn;
        @(negedge clk); bus.StartE = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        check("rstRun/vec", bus.VecResult, 64'd0);
        check("rstRun/acc", 64'(bus.AccResult), 64'd0);
        check("rstRun/valid", 64'(bus.ResultValid), 64'd0);
        check("rstRun/busy", 64'(bus.Busy), 64'd0);
        mVec = '0;
        mAcc = '0;
        repeat (6) begin @(negedge clk); #1; sawRv |= bus.ResultValid; end
        check("rstRun/noValid", 64'(sawRv), 64'd0);

        runOp(tbl[1], "afterReset");
        check("sbEmpty", 64'(sbQ.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
